// File: rtl/addr_reg_pkg.sv
// Shared op codes for the address register bank.
package addr_reg_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP        = 3'd0;
    localparam logic [OP_W-1:0] OP_LOAD       = 3'd1;
    localparam logic [OP_W-1:0] OP_INC        = 3'd2;
    localparam logic [OP_W-1:0] OP_DEC        = 3'd3;
    localparam logic [OP_W-1:0] OP_INCS       = 3'd4;
    localparam logic [OP_W-1:0] OP_DECS       = 3'd5;
    localparam logic [OP_W-1:0] OP_COMMIT     = 3'd6;
    localparam logic [OP_W-1:0] OP_COMMIT_ALL = 3'd7;

endpackage

// File: rtl/addr_reg_alu.sv
// Unit/stride incrementer-decrementer for the address bank.
// ADDR_REG_SAT_EN selects clamping instead of modulo wrap-around.
module addr_reg_alu
    import addr_reg_pkg::*;
#(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned STRIDE = 256
) (
    input  logic [WIDTH-1:0] a,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    localparam logic [WIDTH-1:0] STEP_S = WIDTH'(STRIDE);

    logic             dec;
    logic [WIDTH-1:0] step;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] raw;

    always_comb begin
        dec  = (op == OP_DEC) || (op == OP_DECS);
        step = ((op == OP_INCS) || (op == OP_DECS)) ? STEP_S : WIDTH'(1);
        sum  = {1'b0, a} + {1'b0, step};
        diff = {1'b0, a} - {1'b0, step};
        // Top bit of the extended result is carry (add) or borrow (sub).
        if (dec) begin
            flag = diff[WIDTH];
            raw  = diff[WIDTH-1:0];
        end else begin
            flag = sum[WIDTH];
            raw  = sum[WIDTH-1:0];
        end
`ifdef ADDR_REG_SAT_EN
        result = flag ? (dec ? '0 : '1) : raw;
`else
        result = raw;
`endif
    end

endmodule

// File: rtl/addr_reg_bank.sv
// Bank of NCH shadowed address registers, falling-edge clocked, with explicit commit.
// ADDR_REG_SAT_EN makes step ops saturate instead of wrapping.
module addr_reg_bank
    import addr_reg_pkg::*;
#(
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned NCH       = 4,
    parameter int unsigned STRIDE    = 256,
    parameter int unsigned RESET_VAL = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [$clog2(NCH)-1:0]   sel,
    input  logic [OP_W-1:0]          op,
    input  logic [WIDTH-1:0]         bus_in,
    output logic [NCH*WIDTH-1:0]     data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [NCH-1:0]           pending,
    output logic                     wrap
);

    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] data_q   [NCH];
    logic [WIDTH-1:0] data_d   [NCH];
    logic [WIDTH-1:0] shadow_q [NCH];
    logic [WIDTH-1:0] shadow_d [NCH];
    logic [NCH-1:0]   pending_q, pending_d;
    logic             wrap_q, wrap_d;

    logic             sel_ok;
    logic             is_arith;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] alu_res;
    logic             alu_flag;

    // Non-power-of-two NCH leaves sel codes with no channel behind them.
    assign sel_ok   = 32'(sel) < NCH;
    assign is_arith = (op == OP_INC) || (op == OP_DEC) || (op == OP_INCS) || (op == OP_DECS);

    always_comb begin
        src     = '0;
        rd_data = '0;
        if (sel_ok) begin
            src     = pending_q[sel] ? shadow_q[sel] : data_q[sel];
            rd_data = data_q[sel];
        end
    end

    addr_reg_alu #(
        .WIDTH  (WIDTH),
        .STRIDE (STRIDE)
    ) u_alu (
        .a      (src),
        .op     (op),
        .result (alu_res),
        .flag   (alu_flag)
    );

    always_comb begin
        data_d    = data_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        wrap_d    = 1'b0;
        if (en && sel_ok) begin
            case (op)
                OP_LOAD: begin
                    shadow_d[sel]  = bus_in;
                    pending_d[sel] = 1'b1;
                end
                OP_INC, OP_DEC, OP_INCS, OP_DECS: begin
                    shadow_d[sel]  = alu_res;
                    pending_d[sel] = 1'b1;
                    wrap_d         = alu_flag && is_arith;
                end
                OP_COMMIT: begin
                    if (pending_q[sel]) begin
                        data_d[sel]    = shadow_q[sel];
                        pending_d[sel] = 1'b0;
                    end
                end
                OP_COMMIT_ALL: begin
                    for (int k = 0; k < int'(NCH); k++) begin
                        if (pending_q[k]) begin
                            data_d[k] = shadow_q[k];
                        end
                    end
                    pending_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NCH); k++) begin
                data_q[k]   <= RST_V;
                shadow_q[k] <= RST_V;
            end
            pending_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            data_q    <= data_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            wrap_q    <= wrap_d;
        end
    end

    for (genvar k = 0; k < int'(NCH); k++) begin : g_data
        assign data[k*WIDTH +: WIDTH] = data_q[k];
    end

    assign pending = pending_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_addr_reg_bank.sv
// Scoreboard bench for addr_reg_bank: driver queues hand-computed state, monitor checks on rising edges.
module tb_addr_reg_bank;
    import addr_reg_pkg::*;

`ifdef ADDR_REG_SAT_EN
    localparam logic [17:0] INC_TOP  = 18'h3FFFF;
    localparam logic [17:0] DEC_BOT  = 18'h00000;
    localparam logic [17:0] DEC_AGN  = 18'h00000;
    localparam logic        DEC_AGNW = 1'b1;
`else
    localparam logic [17:0] INC_TOP  = 18'h00000;
    localparam logic [17:0] DEC_BOT  = 18'h3FFFF;
    localparam logic [17:0] DEC_AGN  = 18'h3FFFE;
    localparam logic        DEC_AGNW = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  sel;
    logic [2:0]  op;
    logic [17:0] bus_in;
    logic [71:0] data;
    logic [17:0] rd_data;
    logic [3:0]  pending;
    logic        wrap;

    addr_reg_bank #(
        .WIDTH     (18),
        .NCH       (4),
        .STRIDE    (256),
        .RESET_VAL (7)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sel     (sel),
        .op      (op),
        .bus_in  (bus_in),
        .data    (data),
        .rd_data (rd_data),
        .pending (pending),
        .wrap    (wrap)
    );

    typedef struct {
        string            name;
        logic [3:0][17:0] d;
        logic [3:0]       p;
        logic             w;
        logic [17:0]      rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input string fld,
                                  input logic [17:0] got, input logic [17:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %h required %h", nm, fld, got, req);
        end
    endfunction

    // Sampled on the rising edge, away from the falling active edge.
    always @(posedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                check(e.name, $sformatf("data[%0d]", k), data[k*18 +: 18], e.d[k]);
            end
            check(e.name, "pending", {14'b0, pending}, {14'b0, e.p});
            check(e.name, "wrap", {17'b0, wrap}, {17'b0, e.w});
            check(e.name, "rd_data", rd_data, e.rd);
        end
    end

    function automatic void push_exp(input string nm, input logic [1:0] s,
                                     input logic [17:0] d0, input logic [17:0] d1,
                                     input logic [17:0] d2, input logic [17:0] d3,
                                     input logic [3:0] p, input logic w);
        exp_t x;
        x.name = nm;
        x.d    = {d3, d2, d1, d0};
        x.p    = p;
        x.w    = w;
        x.rd   = x.d[s];
        exp_q.push_back(x);
    endfunction

    task automatic drive(input string nm, input logic e, input logic [2:0] o,
                         input logic [1:0] s, input logic [17:0] b,
                         input logic [17:0] d0, input logic [17:0] d1,
                         input logic [17:0] d2, input logic [17:0] d3,
                         input logic [3:0] p, input logic w);
        @(posedge clk);
        #1;
        en     = e;
        op     = o;
        sel    = s;
        bus_in = b;
        push_exp(nm, s, d0, d1, d2, d3, p, w);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        op     = OP_NOP;
        sel    = 2'd0;
        bus_in = '0;
        #7 rst = 1'b0;

        //     name          en    op             sel   bus       d0      d1      d2        d3        pend     wrap
        drive("init",       1'b0, OP_NOP,        2'd0, 18'h0,    18'd7,  18'd7,  18'd7,    18'd7,    4'b0000, 1'b0);
        drive("load2",      1'b1, OP_LOAD,       2'd2, 18'h100,  18'd7,  18'd7,  18'd7,    18'd7,    4'b0100, 1'b0);
        drive("commit2",    1'b1, OP_COMMIT,     2'd2, 18'h0,    18'd7,  18'd7,  18'h100,  18'd7,    4'b0000, 1'b0);
        drive("inc0_a",     1'b1, OP_INC,        2'd0, 18'h0,    18'd7,  18'd7,  18'h100,  18'd7,    4'b0001, 1'b0);
        drive("inc0_b",     1'b1, OP_INC,        2'd0, 18'h0,    18'd7,  18'd7,  18'h100,  18'd7,    4'b0001, 1'b0);
        drive("inc0_c",     1'b1, OP_INC,        2'd0, 18'h0,    18'd7,  18'd7,  18'h100,  18'd7,    4'b0001, 1'b0);
        drive("commit0",    1'b1, OP_COMMIT,     2'd0, 18'h0,    18'd10, 18'd7,  18'h100,  18'd7,    4'b0000, 1'b0);
        drive("incs1",      1'b1, OP_INCS,       2'd1, 18'h0,    18'd10, 18'd7,  18'h100,  18'd7,    4'b0010, 1'b0);
        drive("decs1",      1'b1, OP_DECS,       2'd1, 18'h0,    18'd10, 18'd7,  18'h100,  18'd7,    4'b0010, 1'b0);
        drive("commit1",    1'b1, OP_COMMIT,     2'd1, 18'h0,    18'd10, 18'd7,  18'h100,  18'd7,    4'b0000, 1'b0);
        drive("load3_max",  1'b1, OP_LOAD,       2'd3, 18'h3FFFF,18'd10, 18'd7,  18'h100,  18'd7,    4'b1000, 1'b0);
        drive("inc3_top",   1'b1, OP_INC,        2'd3, 18'h0,    18'd10, 18'd7,  18'h100,  18'd7,    4'b1000, 1'b1);
        drive("nop_wrapclr",1'b1, OP_NOP,        2'd3, 18'h0,    18'd10, 18'd7,  18'h100,  18'd7,    4'b1000, 1'b0);
        drive("commit3_a",  1'b1, OP_COMMIT,     2'd3, 18'h0,    18'd10, 18'd7,  18'h100,  INC_TOP,  4'b0000, 1'b0);
        drive("load3_zero", 1'b1, OP_LOAD,       2'd3, 18'h0,    18'd10, 18'd7,  18'h100,  INC_TOP,  4'b1000, 1'b0);
        drive("dec3_bot",   1'b1, OP_DEC,        2'd3, 18'h0,    18'd10, 18'd7,  18'h100,  INC_TOP,  4'b1000, 1'b1);
        drive("commit3_b",  1'b1, OP_COMMIT,     2'd3, 18'h0,    18'd10, 18'd7,  18'h100,  DEC_BOT,  4'b0000, 1'b0);
        drive("dec3_vis",   1'b1, OP_DEC,        2'd3, 18'h0,    18'd10, 18'd7,  18'h100,  DEC_BOT,  4'b1000, DEC_AGNW);
        drive("commit3_c",  1'b1, OP_COMMIT,     2'd3, 18'h0,    18'd10, 18'd7,  18'h100,  DEC_AGN,  4'b0000, 1'b0);
        drive("load0_5",    1'b1, OP_LOAD,       2'd0, 18'd5,    18'd10, 18'd7,  18'h100,  DEC_AGN,  4'b0001, 1'b0);
        drive("load1_9",    1'b1, OP_LOAD,       2'd1, 18'd9,    18'd10, 18'd7,  18'h100,  DEC_AGN,  4'b0011, 1'b0);
        drive("commit_all", 1'b1, OP_COMMIT_ALL, 2'd0, 18'h0,    18'd5,  18'd9,  18'h100,  DEC_AGN,  4'b0000, 1'b0);
        drive("en_low",     1'b0, OP_LOAD,       2'd0, 18'h123,  18'd5,  18'd9,  18'h100,  DEC_AGN,  4'b0000, 1'b0);
        drive("load2_50",   1'b1, OP_LOAD,       2'd2, 18'h50,   18'd5,  18'd9,  18'h100,  DEC_AGN,  4'b0100, 1'b0);
        drive("inc2_acc",   1'b1, OP_INC,        2'd2, 18'h0,    18'd5,  18'd9,  18'h100,  DEC_AGN,  4'b0100, 1'b0);

        // Reset pulse between falling edges: state must clear with no clock edge.
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        push_exp("async_rst", sel, 18'd7, 18'd7, 18'd7, 18'd7, 4'b0000, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        drive("commit2_post",1'b1, OP_COMMIT,    2'd2, 18'h0,    18'd7,  18'd7,  18'd7,    18'd7,    4'b0000, 1'b0);
        drive("inc1_post",  1'b1, OP_INC,        2'd1, 18'h0,    18'd7,  18'd7,  18'd7,    18'd7,    4'b0010, 1'b0);
        drive("commit_all3",1'b1, OP_COMMIT_ALL, 2'd3, 18'h0,    18'd7,  18'd8,  18'd7,    18'd7,    4'b0000, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addr_reg_bank.md
# addr_reg_bank

Parametrised bank of NCH pointer/address registers for the down-sampling datapath, each with a private shadow stage and a separately committed visible value. Generalises the single 18-bit swap register: per-channel select, unit or stride step in both directions, multi-step accumulation in the shadow, single-channel or bank-wide commit, and carry/borrow reporting. Sits between the processor bus and the memory-address/loop-counter logic; visible values feed address generation directly.

## Interface
- WIDTH, 18, register width in bits
- NCH, 4, number of channels (≥2)
- STRIDE, 256, step used by stride ops (image row pitch); must be < 2^WIDTH
- RESET_VAL, 7, reset value of every shadow and visible register
- clk  in  1  clock; all state updates on falling edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  op qualifier; op ignored when low
- sel  in  $clog2(NCH)  target channel
- op  in  3  operation code (see Operation)
- bus_in  in  WIDTH  load value
- data  out  NCH*WIDTH  visible registers, channel k at [k*WIDTH +: WIDTH]
- rd_data  out  WIDTH  combinational visible value of channel sel (0 if sel ≥ NCH)
- pending  out  NCH  shadow holds an uncommitted value
- wrap  out  1  one-cycle registered flag: last arithmetic op wrapped (or saturated)

## Operation
- Op codes: 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 INCS, 5 DECS, 6 COMMIT, 7 COMMIT_ALL.
- One op per qualified cycle; no op when en=0 (state holds, wrap clears).
- LOAD: shadow[sel] ← bus_in; pending[sel] ← 1.
- INC/DEC: step 1; INCS/DECS: step STRIDE. Source operand = shadow[sel] if pending[sel], else data[sel]. Result → shadow[sel]; pending[sel] ← 1. Consecutive steps before commit accumulate.
- Arithmetic modulo 2^WIDTH; wrap ← 1 when carry out (inc) or borrow (dec), else 0.
- COMMIT: if pending[sel], data[sel] ← shadow[sel], pending[sel] ← 0; otherwise no change.
- COMMIT_ALL: every channel with pending set commits in the same edge; all pending clear.
- sel ≥ NCH: op treated as NOP.
- Non-arithmetic ops and NOP drive wrap ← 0.
- Visible data changes only on COMMIT/COMMIT_ALL or reset.

## Timing
- rst asserted: immediately (no clock) data and shadows = RESET_VAL, pending = 0, wrap = 0; held while rst high. Reset mid-accumulation discards shadow contents.
- First op accepted on first falling edge after rst deasserts.
- LOAD/step → pending visible after that edge; data unchanged until a later COMMIT edge (minimum 2 edges from load to visible).
- wrap valid for exactly the cycle following the arithmetic op.
- rd_data tracks sel and data combinationally, zero latency.

## Configuration
- ADDR_REG_SAT_EN defined: INC/INCS clamp at 2^WIDTH−1, DEC/DECS clamp at 0; wrap reports that clamping occurred.
- Undefined: modulo wrap-around as above.

## Structure
- Package addr_reg_pkg: op code constants, OP_W = 3.
- Sub-module addr_reg_alu: combinational WIDTH-bit add/sub of step 1 or STRIDE, returning result and wrap/saturate flag; instantiated once, muxed by sel.

## Test plan
- Reset: pulse rst between edges → all data = 7, pending = 0, wrap = 0 without a clock edge.
- LOAD ch2 0x00100, then COMMIT ch2 → pending[2] high after load, data ch2 = 0x00100 only after commit edge; other channels stay 7.
- INC ch0 three times then COMMIT → data ch0 = 10; INCS ch1 then DECS ch1 then COMMIT → data ch1 = 7.
- LOAD ch3 0x3FFFF, INC → wrap = 1 for one cycle, shadow 0 (ADDR_REG_SAT_EN: shadow 0x3FFFF, wrap = 1); LOAD 0, DEC → 0x3FFFF, wrap = 1 (SAT: 0).
- LOAD ch0 5, LOAD ch1 9, COMMIT_ALL → data ch0 = 5, ch1 = 9, pending = 0 same edge; en = 0 with op = LOAD → no change.
- Assert rst during pending ch2 accumulation → shadow discarded; subsequent COMMIT ch2 leaves data = 7.
